// File: rtl/noc_output_allocator.sv
// Purpose: per-output switch allocator with wormhole locking and downstream credit tracking.
// Latency: req -> grant next cycle; pops start the same cycle the grant is visible; 1-cycle bubble between packets.
// Backpressure: pops stall when credits are 0 or the locked input has no flit; the lock is held with no timeout.
module noc_output_allocator #(
  parameter int NUM_INPUTS        = 5,
  parameter int FLIT_BUFFER_DEPTH = 1,
  parameter int CREDIT_WIDTH      = $clog2(FLIT_BUFFER_DEPTH + 1)
) (
  input  logic                    clk_noc,
  input  logic                    rst_noc_sync,
  input  logic [NUM_INPUTS-1:0]   req,
  input  logic [NUM_INPUTS-1:0]   flit_valid,
  input  logic [NUM_INPUTS-1:0]   is_tail,
  input  logic [NUM_INPUTS-1:0]   turn_disable,
  input  logic                    credit_in,
  output logic [NUM_INPUTS-1:0]   grant,
  output logic [NUM_INPUTS-1:0]   pop,
  output logic                    send_out,
  output logic [CREDIT_WIDTH-1:0] credits,
  output logic                    credit_err
);

  localparam int IDX_W = (NUM_INPUTS > 1) ? $clog2(NUM_INPUTS) : 1;
  localparam logic [CREDIT_WIDTH-1:0] CRED_MAX = CREDIT_WIDTH'(FLIT_BUFFER_DEPTH);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_INPUTS - 1);

  typedef enum logic {IDLE, LOCKED} state_t;

  state_t                  state_q, state_d;
  logic [NUM_INPUTS-1:0]   grant_q, grant_d;
  logic [IDX_W-1:0]        g_idx_q, g_idx_d;
  logic [IDX_W-1:0]        rr_ptr_q, rr_ptr_d;
  logic [CREDIT_WIDTH-1:0] credits_q;
  logic                    credit_err_q;

  logic [NUM_INPUTS-1:0]   elig;
  logic [NUM_INPUTS-1:0]   pop_raw;
  logic                    tail_go;
  logic                    found;
  logic [IDX_W-1:0]        win;
  int                      idx;

  assign elig = req & ~turn_disable;

  // State register: lock state, granted input and round-robin pointer.
  always_ff @(posedge clk_noc) begin
    if (rst_noc_sync) begin
      state_q  <= IDLE;
      grant_q  <= '0;
      g_idx_q  <= '0;
      rr_ptr_q <= '0;
    end else begin
      state_q  <= state_d;
      grant_q  <= grant_d;
      g_idx_q  <= g_idx_d;
      rr_ptr_q <= rr_ptr_d;
    end
  end

  // Next state: round-robin pick from rr_ptr when idle, release on tail departure when locked.
  always_comb begin
    state_d  = state_q;
    grant_d  = grant_q;
    g_idx_d  = g_idx_q;
    rr_ptr_d = rr_ptr_q;
    pop_raw  = '0;
    tail_go  = 1'b0;
    found    = 1'b0;
    win      = '0;
    idx      = 0;
    case (state_q)
      IDLE: begin
        for (int k = 0; k < NUM_INPUTS; k++) begin
          idx = (int'(rr_ptr_q) + k) % NUM_INPUTS;
          if (!found && elig[idx]) begin
            found = 1'b1;
            win   = IDX_W'(idx);
          end
        end
        if (found) begin
          state_d = LOCKED;
          grant_d = {{(NUM_INPUTS-1){1'b0}}, 1'b1} << win;
          g_idx_d = win;
        end
      end
      LOCKED: begin
        // grant_q is one-hot, so this is only ever the locked input's bit.
        pop_raw = grant_q & flit_valid & {NUM_INPUTS{credits_q != '0}};
        tail_go = |(pop_raw & is_tail);
        if (tail_go) begin
          state_d  = IDLE;
          grant_d  = '0;
          rr_ptr_d = (g_idx_q == LAST_IDX) ? '0 : g_idx_q + 1'b1;
        end
      end
      default: begin
        state_d = IDLE;
        grant_d = '0;
      end
    endcase
  end

  // Dequeue strobes are suppressed while reset is held so nothing leaves a buffer being flushed.
  assign pop      = rst_noc_sync ? '0 : pop_raw;
  assign send_out = |pop;

  // Credit counter: a departing flit consumes a slot, a returned credit frees one, both cancel.
  always_ff @(posedge clk_noc) begin
    if (rst_noc_sync) begin
      credits_q    <= CRED_MAX;
      credit_err_q <= 1'b0;
    end else begin
      case ({send_out, credit_in})
        2'b10: credits_q <= credits_q - 1'b1;
        2'b01: begin
          if (credits_q == CRED_MAX) begin
            credit_err_q <= 1'b1;
          end else begin
            credits_q <= credits_q + 1'b1;
          end
        end
        default: credits_q <= credits_q;
      endcase
    end
  end

  assign grant      = grant_q;
  assign credits    = credits_q;
  assign credit_err = credit_err_q;

endmodule

// File: tb/tb_noc_output_allocator.sv
// Bench for noc_output_allocator: directed scenarios plus randomized traffic,
// all checked cycle by cycle against a packet-level reference model.
// The instance uses a 4-deep downstream buffer so multi-flit credit effects are visible.
module tb_noc_output_allocator;

  localparam int N = 5;
  localparam int D = 4;
  localparam int CW = $clog2(D + 1);

  logic          clk_noc = 1'b0;
  logic          rst_noc_sync;
  logic [N-1:0]  req, flit_valid, is_tail, turn_disable;
  logic          credit_in;
  logic [N-1:0]  grant, pop;
  logic          send_out;
  logic [CW-1:0] credits;
  logic          credit_err;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model state
  bit m_locked;
  int m_g;
  int m_rr;
  int m_cred;
  bit m_err;

  // Values observed mid-cycle of the last step
  logic [N-1:0] last_pop;
  logic         last_send;

  noc_output_allocator #(
    .NUM_INPUTS(N),
    .FLIT_BUFFER_DEPTH(D)
  ) dut (
    .clk_noc(clk_noc),
    .rst_noc_sync(rst_noc_sync),
    .req(req),
    .flit_valid(flit_valid),
    .is_tail(is_tail),
    .turn_disable(turn_disable),
    .credit_in(credit_in),
    .grant(grant),
    .pop(pop),
    .send_out(send_out),
    .credits(credits),
    .credit_err(credit_err)
  );

  always #5 clk_noc = ~clk_noc;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // One clock cycle: drive inputs, compare all outputs with the model mid-cycle, then advance the model.
  task automatic step(input logic [N-1:0] r, input logic [N-1:0] fv, input logic [N-1:0] tl,
                      input logic [N-1:0] td, input logic ci, input logic rs);
    logic [N-1:0] exp_pop;
    logic [N-1:0] exp_grant;
    logic [N-1:0] elig;
    bit snd;
    bit picked;
    req = r; flit_valid = fv; is_tail = tl; turn_disable = td; credit_in = ci; rst_noc_sync = rs;
    @(negedge clk_noc);
    exp_grant = m_locked ? N'(1 << m_g) : '0;
    exp_pop   = (!rs && m_locked && fv[m_g] && m_cred > 0) ? N'(1 << m_g) : '0;
    check("grant", 32'(grant), 32'(exp_grant));
    check("pop", 32'(pop), 32'(exp_pop));
    check("send_out", 32'(send_out), 32'(exp_pop != 0));
    check("credits", 32'(credits), 32'(m_cred));
    check("credit_err", 32'(credit_err), 32'(m_err));
    last_pop  = pop;
    last_send = send_out;
    @(posedge clk_noc);
    #1;
    if (rs) begin
      m_locked = 0; m_rr = 0; m_cred = D; m_err = 0; m_g = 0;
    end else begin
      snd = (exp_pop != 0);
      if (snd && !ci) m_cred--;
      else if (ci && !snd) begin
        if (m_cred == D) m_err = 1;
        else m_cred++;
      end
      if (!m_locked) begin
        elig = r & ~td;
        picked = 0;
        for (int k = 0; k < N; k++) begin
          int i;
          i = (m_rr + k) % N;
          if (!picked && elig[i]) begin
            picked = 1; m_g = i; m_locked = 1;
          end
        end
      end else if (snd && tl[m_g]) begin
        m_locked = 0;
        m_rr = (m_g + 1) % N;
      end
    end
  endtask

  task automatic idle(input logic ci);
    step('0, '0, '0, '0, ci, 1'b0);
  endtask

  task automatic do_reset();
    step('0, '0, '0, '0, 1'b0, 1'b1);
    step('0, '0, '0, '0, 1'b0, 1'b1);
  endtask

  logic [N-1:0] rr_grants[11];
  int pops;

  initial begin
    m_locked = 0; m_g = 0; m_rr = 0; m_cred = D; m_err = 0;
    req = '0; flit_valid = '0; is_tail = '0; turn_disable = '0; credit_in = 1'b0; rst_noc_sync = 1'b1;
    last_pop = '0; last_send = 1'b0;
    do_reset();
    check("rst_grant", 32'(grant), 32'd0);
    check("rst_credits", 32'(credits), 32'd4);
    check("rst_err", 32'(credit_err), 32'd0);

    // Single input, 3-flit packet on input 1
    step(5'b00010, 5'b00010, 5'b00000, '0, 1'b0, 1'b0);
    check("a_grant", 32'(grant), 32'b00010);
    pops = 0;
    step(5'b00010, 5'b00010, 5'b00000, '0, 1'b0, 1'b0); pops += (last_pop == 5'b00010) ? 1 : 0;
    step(5'b00000, 5'b00010, 5'b00000, '0, 1'b0, 1'b0); pops += (last_pop == 5'b00010) ? 1 : 0;
    step(5'b00000, 5'b00010, 5'b00010, '0, 1'b0, 1'b0); pops += (last_pop == 5'b00010) ? 1 : 0;
    check("a_pops", 32'(pops), 32'd3);
    check("a_credits", 32'(credits), 32'd1);
    check("a_idle_grant", 32'(grant), 32'd0);

    // Refill to max, then one extra credit overflows
    idle(1'b1); idle(1'b1); idle(1'b1);
    check("refill_credits", 32'(credits), 32'd4);
    check("refill_err", 32'(credit_err), 32'd0);
    idle(1'b1);
    check("ovf_credits", 32'(credits), 32'd4);
    check("ovf_err", 32'(credit_err), 32'd1);
    idle(1'b0); idle(1'b0);
    check("ovf_sticky", 32'(credit_err), 32'd1);
    do_reset();
    check("ovf_cleared", 32'(credit_err), 32'd0);

    // Round-robin over all inputs with single-flit packets; credits returned right after each send
    for (int c = 0; c < 11; c++) begin
      step(5'b11111, 5'b11111, 5'b11111, '0, last_send, 1'b0);
      rr_grants[c] = grant;
    end
    for (int k = 0; k < 6; k++) check("rr_order", 32'(rr_grants[2*k]), 32'(1 << (k % N)));
    for (int k = 0; k < 5; k++) check("rr_bubble", 32'(rr_grants[2*k+1]), 32'd0);
    check("rr_err", 32'(credit_err), 32'd0);

    // Credit stall on input 2: drain all credits, stall, then one credit releases the tail
    do_reset();
    step(5'b00100, 5'b00100, '0, '0, 1'b0, 1'b0);
    for (int k = 0; k < D; k++) step('0, 5'b00100, '0, '0, 1'b0, 1'b0);
    check("stall_credits", 32'(credits), 32'd0);
    for (int k = 0; k < 3; k++) begin
      step('0, 5'b00100, 5'b00100, '0, 1'b0, 1'b0);
      check("stall_nopop", 32'(last_pop), 32'd0);
    end
    check("stall_lock", 32'(grant), 32'b00100);
    step('0, 5'b00100, 5'b00100, '0, 1'b1, 1'b0);
    check("stall_cin_nopop", 32'(last_pop), 32'd0);
    step('0, 5'b00100, 5'b00100, '0, 1'b0, 1'b0);
    check("stall_release_pop", 32'(last_pop), 32'b00100);
    check("stall_end_grant", 32'(grant), 32'd0);

    // Send and credit return in the same cycle at credits == 2
    do_reset();
    step(5'b00001, 5'b00001, '0, '0, 1'b0, 1'b0);
    step('0, 5'b00001, '0, '0, 1'b0, 1'b0);
    step('0, 5'b00001, '0, '0, 1'b0, 1'b0);
    check("sim_pre", 32'(credits), 32'd2);
    step('0, 5'b00001, '0, '0, 1'b1, 1'b0);
    check("sim_send", 32'(last_send), 32'd1);
    check("sim_credits", 32'(credits), 32'd2);
    step('0, 5'b00001, 5'b00001, '0, 1'b0, 1'b0);

    // Turn mask: input 2 forbidden, input 1 wins; masking input 1 mid-lock does not break the packet
    do_reset();
    step(5'b00110, 5'b00110, '0, 5'b00100, 1'b0, 1'b0);
    check("turn_grant", 32'(grant), 32'b00010);
    step(5'b00110, 5'b00110, '0, 5'b00010, 1'b0, 1'b0);
    check("turn_pop1", 32'(last_pop), 32'b00010);
    step(5'b00100, 5'b00110, 5'b00010, 5'b00010, 1'b0, 1'b0);
    check("turn_pop2", 32'(last_pop), 32'b00010);
    check("turn_done", 32'(grant), 32'd0);

    // Reset in the middle of a packet on input 3
    do_reset();
    step(5'b01000, 5'b01000, '0, '0, 1'b0, 1'b0);
    step('0, 5'b01000, '0, '0, 1'b0, 1'b0);
    step('0, 5'b01000, '0, '0, 1'b0, 1'b1);
    check("mid_rst_pop", 32'(last_pop), 32'd0);
    check("mid_rst_grant", 32'(grant), 32'd0);
    check("mid_rst_credits", 32'(credits), 32'd4);
    step(5'b11111, '0, '0, '0, 1'b0, 1'b0);
    check("mid_rst_rr", 32'(grant), 32'b00001);

    // Randomized traffic
    do_reset();
    for (int c = 0; c < 3000; c++) begin
      logic [N-1:0] r, fv, tl, td;
      logic ci, rs;
      r  = N'($urandom);
      fv = N'($urandom) | N'($urandom);
      tl = N'($urandom) & N'($urandom);
      td = N'($urandom) & N'($urandom) & N'($urandom);
      ci = ($urandom_range(0, 2) == 0);
      rs = ($urandom_range(0, 199) == 0);
      step(r, fv, tl, td, ci, rs);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
